// File: rtl/versat_databus_arbiter.sv
// Burst-locked arbiter sharing one external-memory databus among N_PORTS Versat I/O units.
// Define VERSAT_DBUS_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module versat_databus_arbiter #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            req_valid,
    output logic [N_PORTS-1:0]            req_ready,
    input  logic [N_PORTS*ADDR_W-1:0]     req_addr,
    input  logic [N_PORTS*DATA_W-1:0]     req_wdata,
    input  logic [N_PORTS*DATA_W/8-1:0]   req_wstrb,
    input  logic [N_PORTS*8-1:0]          req_len,
    output logic [DATA_W-1:0]             req_rdata,
    output logic [N_PORTS-1:0]            req_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W/8-1:0]           m_wstrb,
    output logic [7:0]                    m_len,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic                          m_last,
    output logic [N_PORTS-1:0]            grant,
    output logic                          busy
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [N_PORTS-1:0] win_oh;
    logic [LEN_W-1:0]   win_len;
    logic               found;
    logic               beat;
    logic               burst_end;

`ifdef VERSAT_DBUS_RR_EN
    localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_idx;

    // Search from the pointer upward first, then wrap to the lowest requester.
    always_comb begin : winner_pick
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (!found && req_valid[i] && (PTR_W'(i) >= ptr_q)) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
                win_idx   = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (!found && req_valid[i]) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
                win_idx   = PTR_W'(i);
            end
        end
    end

    always_comb begin : ptr_next
        ptr_d = ptr_q;
        if ((state_q == IDLE) && found) begin
            ptr_d = (win_idx == PTR_W'(N_PORTS - 1)) ? '0 : PTR_W'(win_idx + 1'b1);
        end
    end

    always_ff @(posedge clk) begin : ptr_reg
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin : winner_pick
        win_oh = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (!found && req_valid[i]) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin : winner_len
        win_len = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (win_oh[i]) begin
                win_len = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Granted port drives the bus; grant_q is zero in IDLE so everything idles low there.
    always_comb begin : bus_mux
        m_valid   = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        req_ready = '0;
        req_last  = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) begin
                m_valid     = req_valid[i];
                m_addr      = req_addr[i*ADDR_W +: ADDR_W];
                m_wdata     = req_wdata[i*DATA_W +: DATA_W];
                m_wstrb     = req_wstrb[i*STRB_W +: STRB_W];
                req_ready[i] = m_ready;
                req_last[i]  = m_last;
            end
        end
    end

    assign beat      = m_valid & m_ready;
    // Length compare releases the bus even if the slave never signals last.
    assign burst_end = m_last | (beat_cnt_q == len_q);

    always_comb begin : fsm_next
        state_d    = state_q;
        grant_d    = grant_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = BURST;
                    grant_d    = win_oh;
                    len_d      = win_len;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (beat) begin
                    beat_cnt_d = LEN_W'(beat_cnt_q + 1'b1);
                    if (burst_end) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin : fsm_reg
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q == BURST);
    assign m_len     = len_q;
    assign req_rdata = m_rdata;

endmodule
